// File: rtl/axil_mem_port_arb_if.sv
// Bundle of the write/read request channels and the SRAM port.
// master: channel FSMs + SRAM macro side; slave: the arbiter.
interface axil_mem_port_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                    wr_req;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_ack;
  logic                    rd_req;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_ack;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output wr_req, wr_addr, wr_data, wr_strb,
    output rd_req, rd_addr, mem_rdata,
    input  wr_ack, rd_ack, rd_data,
    input  mem_en, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_strb,
    input  rd_req, rd_addr, mem_rdata,
    output wr_ack, rd_ack, rd_data,
    output mem_en, mem_we, mem_addr,
    output mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/axil_mem_port_arb.sv
// Round-robin arbiter for the single-port SRAM shared by the AXI4-Lite
// write and read channel FSMs. Sequence: issue, (capture), acknowledge.
// Ports: CLK; RST sync active-high; bus (slave modport) carries
//   wr_req/addr/data/strb/ack, rd_req/addr/ack/data and the mem_* port;
//   busy is high whenever an access is in flight.
// Option ARB_STALL_CNT_EN adds saturating wr_stall_cnt/rd_stall_cnt.
module axil_mem_port_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic CLK,
  input  logic RST,
  axil_mem_port_arb_if.slave bus,
  output logic busy
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0] wr_stall_cnt,
  output logic [15:0] rd_stall_cnt
`endif
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_CAPTURE,
    DONE
  } state_t;

  state_t state;
  state_t nxt;
  logic   rr_prefer_rd;
  logic   gnt_wr;
  logic   gnt_rd;

  logic                  en_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [SW-1:0]         wstrb_d;
  logic                  wr_ack_d;
  logic                  rd_ack_d;
  logic                  busy_d;

  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    nxt    = state;
    unique case (state)
      IDLE: begin
        gnt_wr = bus.wr_req &
                 (~bus.rd_req | ~rr_prefer_rd);
        gnt_rd = bus.rd_req & ~gnt_wr;
        if (gnt_wr)      nxt = WR_ISSUE;
        else if (gnt_rd) nxt = RD_ISSUE;
      end
      WR_ISSUE:   nxt = DONE;
      RD_ISSUE:   nxt = RD_CAPTURE;
      RD_CAPTURE: nxt = DONE;
      DONE:       nxt = IDLE;
      default:    nxt = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the
  // transition being taken rather than the current state.
  always_comb begin
    en_d     = gnt_wr | gnt_rd;
    we_d     = gnt_wr;
    addr_d   = '0;
    wdata_d  = '0;
    wstrb_d  = '0;
    if (gnt_wr) begin
      addr_d  = bus.wr_addr;
      wdata_d = bus.wr_data;
      wstrb_d = bus.wr_strb;
    end else if (gnt_rd) begin
      addr_d  = bus.rd_addr;
    end
    wr_ack_d = (state == WR_ISSUE);
    rd_ack_d = (state == RD_CAPTURE);
    busy_d   = (nxt != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      rr_prefer_rd  <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      bus.wr_ack    <= 1'b0;
      bus.rd_ack    <= 1'b0;
      bus.rd_data   <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= nxt;
      if (gnt_wr)      rr_prefer_rd <= 1'b1;
      else if (gnt_rd) rr_prefer_rd <= 1'b0;
      bus.mem_en    <= en_d;
      bus.mem_we    <= we_d;
      bus.mem_addr  <= addr_d;
      bus.mem_wdata <= wdata_d;
      bus.mem_wstrb <= wstrb_d;
      bus.wr_ack    <= wr_ack_d;
      bus.rd_ack    <= rd_ack_d;
      busy          <= busy_d;
      // SRAM data is valid the cycle after the read strobe.
      if (state == RD_CAPTURE)
        bus.rd_data <= bus.mem_rdata;
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic wr_act;
  logic rd_act;

  // The ack cycle still belongs to the access, so the DONE state
  // is attributed to whichever side is being acknowledged.
  assign wr_act = (state == WR_ISSUE) |
                  ((state == DONE) & bus.wr_ack);
  assign rd_act = (state == RD_ISSUE) |
                  (state == RD_CAPTURE) |
                  ((state == DONE) & bus.rd_ack);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_stall_cnt <= '0;
      rd_stall_cnt <= '0;
    end else begin
      if (bus.wr_req & ~gnt_wr & ~wr_act &
          (wr_stall_cnt != 16'hFFFF))
        wr_stall_cnt <= wr_stall_cnt + 16'd1;
      if (bus.rd_req & ~gnt_rd & ~rd_act &
          (rd_stall_cnt != 16'hFFFF))
        rd_stall_cnt <= rd_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axil_mem_port_arb.sv
// Scoreboard bench for axil_mem_port_arb: transaction-level model
// predicts grants, SRAM strobes, acks and read data; monitor checks.
module tb_axil_mem_port_arb;
  localparam int DW = 32;
  localparam int AW = 6;

  logic CLK = 1'b0;
  logic RST;
  logic busy;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] wr_stall_cnt;
  logic [15:0] rd_stall_cnt;
`endif

  always #5 CLK = ~CLK;

  axil_mem_port_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  axil_mem_port_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus),
    .busy(busy)
`ifdef ARB_STALL_CNT_EN
    ,
    .wr_stall_cnt(wr_stall_cnt),
    .rd_stall_cnt(rd_stall_cnt)
`endif
  );

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          scr;
  } wjob_t;
  typedef struct {
    logic [5:0] a;
    bit         scr;
  } rjob_t;
  typedef struct {
    int          cyc;
    bit          we;
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
  } op_t;
  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] d;
  } ack_t;

  wjob_t wq[$];
  rjob_t rq[$];
  op_t   opq[$];
  ack_t  ackq[$];
  byte   op_log[$];

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int next_free = 0;
  int wr_end = 0;
  int rd_end = 0;
  int wcnt = 0;
  int rcnt = 0;
  bit prefer = 1'b0;
  bit mon_on = 1'b0;
  logic [31:0] hold = '0;
  logic [31:0] ref_mem[64];
  logic [31:0] sram[64];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] d,
    input logic [3:0]  s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [5:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 6'h3F;
    return 6'($urandom_range(0, 7));
  endfunction

  // SRAM macro: garbage on rdata except the cycle after a read strobe
  always @(posedge CLK) begin
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1)
      sram[bus.mem_addr] <= merge(sram[bus.mem_addr],
                                  bus.mem_wdata, bus.mem_wstrb);
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0)
      bus.mem_rdata <= sram[bus.mem_addr];
    else
      bus.mem_rdata <= $urandom;
  end

  // Reference model: one access at a time; write costs 3 cycles,
  // read 4; ties alternate starting with write after reset.
  bit gw;
  bit gr;
  always @(posedge CLK) begin
    if (RST) begin
      opq.delete();
      ackq.delete();
      next_free = edge_n + 1;
      prefer = 1'b0;
      hold = '0;
      wr_end = 0;
      rd_end = 0;
      wcnt = 0;
      rcnt = 0;
    end else begin
      gw = 1'b0;
      gr = 1'b0;
      if (edge_n >= next_free) begin
        if (bus.wr_req && (!bus.rd_req || !prefer)) gw = 1'b1;
        else if (bus.rd_req) gr = 1'b1;
      end
      if (bus.wr_req && !gw && !(edge_n < wr_end) && wcnt < 65535)
        wcnt++;
      if (bus.rd_req && !gr && !(edge_n < rd_end) && rcnt < 65535)
        rcnt++;
      if (gw) begin
        ref_mem[bus.wr_addr] = merge(ref_mem[bus.wr_addr],
                                     bus.wr_data, bus.wr_strb);
        opq.push_back('{edge_n + 1, 1'b1, bus.wr_addr,
                        bus.wr_data, bus.wr_strb});
        ackq.push_back('{edge_n + 2, 1'b0, 32'h0});
        next_free = edge_n + 3;
        wr_end = edge_n + 3;
        prefer = 1'b1;
      end
      if (gr) begin
        opq.push_back('{edge_n + 1, 1'b0, bus.rd_addr,
                        32'h0, 4'h0});
        ackq.push_back('{edge_n + 3, 1'b1, ref_mem[bus.rd_addr]});
        next_free = edge_n + 4;
        rd_end = edge_n + 4;
        prefer = 1'b0;
      end
    end
    edge_n++;
  end

  // Monitor: cycle number after edge e is e+1 == edge_n
  op_t  o;
  ack_t ak;
  always @(negedge CLK) begin
    if (mon_on) begin
      if (bus.mem_en === 1'b1)
        op_log.push_back(bus.mem_we ? 8'h57 : 8'h52);
      if (opq.size() > 0 && opq[0].cyc == edge_n) begin
        o = opq.pop_front();
        chk("mem_en", bus.mem_en, 1);
        chk("mem_we", bus.mem_we, o.we);
        chk("mem_addr", bus.mem_addr, o.a);
        chk("mem_wstrb", bus.mem_wstrb, o.s);
        if (o.we) chk("mem_wdata", bus.mem_wdata, o.d);
      end else begin
        chk("mem_en_quiet", {bus.mem_en, bus.mem_we}, 0);
      end
      if (ackq.size() > 0 && ackq[0].cyc == edge_n) begin
        ak = ackq.pop_front();
        if (ak.rd) hold = ak.d;
        chk("acks", {bus.wr_ack, bus.rd_ack}, {!ak.rd, ak.rd});
      end else begin
        chk("acks_quiet", {bus.wr_ack, bus.rd_ack}, 0);
      end
      chk("rd_data", bus.rd_data, hold);
      chk("busy", busy, edge_n < next_free);
`ifdef ARB_STALL_CNT_EN
      chk("wr_stall", wr_stall_cnt, wcnt);
      chk("rd_stall", rd_stall_cnt, rcnt);
`endif
    end
  end

  // Write requester: level req held until ack, dropped next cycle
  logic  wa;
  bit    wscr;
  wjob_t wj;
  initial begin
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_strb = '0;
    wscr = 1'b0;
    forever begin
      @(negedge CLK);
      wa = bus.wr_ack;
      @(posedge CLK);
      #1;
      if (bus.wr_req && wa === 1'b1) begin
        bus.wr_req = 1'b0;
      end else if (!bus.wr_req && wq.size() > 0) begin
        wj = wq.pop_front();
        bus.wr_addr = wj.a;
        bus.wr_data = wj.d;
        bus.wr_strb = wj.s;
        wscr = wj.scr;
        bus.wr_req = 1'b1;
      end else if (bus.wr_req && wscr &&
                   $urandom_range(0, 2) == 0) begin
        bus.wr_addr = rnd_addr();
        bus.wr_data = $urandom;
        bus.wr_strb = 4'($urandom_range(0, 15));
      end
    end
  end

  // Read requester
  logic  ra;
  bit    rscr;
  rjob_t rj;
  initial begin
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
    rscr = 1'b0;
    forever begin
      @(negedge CLK);
      ra = bus.rd_ack;
      @(posedge CLK);
      #1;
      if (bus.rd_req && ra === 1'b1) begin
        bus.rd_req = 1'b0;
      end else if (!bus.rd_req && rq.size() > 0) begin
        rj = rq.pop_front();
        bus.rd_addr = rj.a;
        rscr = rj.scr;
        bus.rd_req = 1'b1;
      end else if (bus.rd_req && rscr &&
                   $urandom_range(0, 2) == 0) begin
        bus.rd_addr = rnd_addr();
      end
    end
  end

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (wq.size() == 0 && rq.size() == 0 &&
          !bus.wr_req && !bus.rd_req && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", done, 1);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = '0;
      sram[i] = '0;
    end
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 mon_on = 1'b1;
    @(negedge CLK);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge CLK);
    #1 RST = 1'b0;

    wq.push_back('{6'h05, 32'hDEADBEEF, 4'hF, 1'b0});
    wait_drain();
    rq.push_back('{6'h05, 1'b0});
    wait_drain();
    chk("rd_after_wr", bus.rd_data, 32'hDEADBEEF);

    do_reset();
    op_log.delete();
    wq.push_back('{6'h11, 32'h12345678, 4'hF, 1'b0});
    rq.push_back('{6'h11, 1'b0});
    wait_drain();
    chk("tie_rd_data", bus.rd_data, 32'h12345678);
`ifdef ARB_STALL_CNT_EN
    chk("stall_rd_3", rd_stall_cnt, 3);
    chk("stall_wr_0", wr_stall_cnt, 0);
`endif
    wq.push_back('{6'h12, 32'hCAFEF00D, 4'hF, 1'b0});
    rq.push_back('{6'h11, 1'b0});
    wait_drain();
    chk("order_len", op_log.size(), 4);
    chk("order_wrwr",
        {op_log[0], op_log[1], op_log[2], op_log[3]},
        32'h57525752);

    wq.push_back('{6'h3F, 32'h0000AB00, 4'b0010, 1'b0});
    wait_drain();
    rq.push_back('{6'h3F, 1'b0});
    wait_drain();
    chk("part_strb", bus.rd_data, 32'h0000AB00);
    wq.push_back('{6'h3F, 32'hFFFFFFFF, 4'h0, 1'b0});
    wait_drain();
    rq.push_back('{6'h3F, 1'b0});
    wait_drain();
    chk("zero_strb", bus.rd_data, 32'h0000AB00);

    rq.push_back('{6'h05, 1'b0});
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(bus.mem_en === 1'b1 && bus.mem_we === 1'b0)
               && n < 20);
    chk("rd_issue_seen", n < 20, 1);
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("abort_rd_data", bus.rd_data, 0);
    chk("abort_mem_en", bus.mem_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", bus.rd_ack, 0);
    n = 0;
    while (bus.rd_ack !== 1'b1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("reread_lat", n, 3);
    chk("reread_data", bus.rd_data, 32'hDEADBEEF);
    wait_drain();

    for (int i = 0; i < 2500; i++) begin
      @(posedge CLK);
      #1;
      if (wq.size() < 2 && $urandom_range(0, 3) == 0)
        wq.push_back('{rnd_addr(), $urandom,
                       4'($urandom_range(0, 15)), 1'b1});
      if (rq.size() < 2 && $urandom_range(0, 3) == 0)
        rq.push_back('{rnd_addr(), 1'b1});
      RST = ($urandom_range(0, 149) == 0);
    end
    RST = 1'b0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
